serial_165_chain_reader: RTL

Input-side counterpart of the 595 output chain driver. It reads NUM_OF_165_LINE parallel daisy-chains of 74HC165 PISO registers, for example limit switches and fault inputs on the motor controller board. On trigger it pulses the parallel-load strobe, then clocks out 8*LINE_BYTES bits per line. All lines are sampled simultaneously, and the result is assembled into one bit-interleaved word. Pin timing is derived from base_clk through a CLK_SCALER tick divider.

---
 rtl/serial_165_chain_reader_pkg.sv | 16 +
 rtl/serial_165_chain_reader_sync.sv | 38 +++
 rtl/serial_165_chain_reader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/serial_165_chain_reader_pkg.sv
// Shared types and helpers for the 74HC165 chain reader.
package serial_165_chain_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SAMPLE = 2'd2,
    SHIFT  = 2'd3
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_165_chain_reader_sync.sv
// N-wide multi-stage synchronizer for asynchronous input buses.
module sync_bus_ff #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_d [STAGES];
  logic [WIDTH-1:0] stage_q [STAGES];

  // Next value of each stage is the previous stage (stage 0 takes the raw input).
  always_comb begin
    stage_d[0] = d;
    for (int unsigned s = 1; s < STAGES; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  // Synchronizer flops, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/serial_165_chain_reader.sv
// Reads parallel daisy-chains of 74HC165 shift registers into one bit-interleaved word.
module serial_165_chain_reader
  import serial_165_chain_reader_pkg::*;
#(
  parameter int unsigned NUM_OF_165_LINE = 16,
  parameter int unsigned LINE_BYTES      = 1,
  parameter int unsigned CLK_SCALER      = 4,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                                  base_clk,
  input  logic                                  rst,
  input  logic                                  trigger,
  input  logic [NUM_OF_165_LINE-1:0]            sdata,
  output logic                                  pl_n,
  output logic                                  sclk,
  output logic                                  busy,
  output logic                                  done,
  output logic [NUM_OF_165_LINE*LINE_BYTES*8-1:0] data_out
);

  localparam int unsigned N  = NUM_OF_165_LINE;
  localparam int unsigned B  = 8 * LINE_BYTES;
  localparam int unsigned W  = N * B;
  localparam int unsigned BW = cnt_width(B);
  localparam int unsigned SW = cnt_width(CLK_SCALER);
  localparam logic [BW-1:0] BIT_LAST    = BW'(B - 1);
  localparam logic [SW-1:0] SCALER_LAST = SW'(CLK_SCALER - 1);

  logic [N-1:0] sdata_sync;

  sync_bus_ff #(
    .WIDTH  (N),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (base_clk),
    .rst (rst),
    .d   (sdata),
    .q   (sdata_sync)
  );

  state_e        state_q,    state_d;
  logic [SW-1:0] scaler_q,   scaler_d;
  logic [BW-1:0] bit_cnt_q,  bit_cnt_d;
  logic [W-1:0]  shift_q,    shift_d;
  logic [W-1:0]  data_out_q, data_out_d;
  logic          pl_n_q,     pl_n_d;
  logic          sclk_q,     sclk_d;
  logic          busy_q,     busy_d;
  logic          done_q,     done_d;
  logic          tick;

  assign tick = (scaler_q == SCALER_LAST);

  // Next-state logic: tick divider, load/sample/shift sequencing and word assembly.
  always_comb begin
    state_d    = state_q;
    scaler_d   = scaler_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    pl_n_d     = pl_n_q;
    sclk_d     = sclk_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q != IDLE) begin
      scaler_d = tick ? '0 : scaler_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d   = LOAD;
          pl_n_d    = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          scaler_d  = '0;
        end
      end
      LOAD: begin
        if (tick) begin
          pl_n_d  = 1'b1;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (tick) begin
          // Oldest sample migrates to the top N bits as later samples arrive.
          shift_d = {shift_q[W-N-1:0], sdata_sync};
          if (bit_cnt_q == BIT_LAST) begin
            data_out_d = shift_d;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            scaler_d   = '0;
            state_d    = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            sclk_d    = 1'b1;
            state_d   = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (tick) begin
          sclk_d  = 1'b0;
          state_d = SAMPLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered pin/status outputs, cleared asynchronously.
  always_ff @(posedge base_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      scaler_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_out_q <= '0;
      pl_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scaler_q   <= scaler_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      pl_n_q     <= pl_n_d;
      sclk_q     <= sclk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign pl_n     = pl_n_q;
  assign sclk     = sclk_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;

endmodule
